// File: rtl/kband_m0_responder_pkg.sv
// Shared constants, FSM state type and burst-length helpers for the
// KBand m0 responder.
package kband_resp_pkg;

  localparam int DATA_W    = 128;
  localparam int BE_W      = 16;
  localparam int BURST_W   = 5;
  localparam int MAX_BURST = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WBURST = 2'd1,
    RBURST = 2'd2
  } state_t;

  // A burstcount is usable as-is only in 1..MAX_BURST.
  function automatic logic burst_ok(input logic [BURST_W-1:0] bc);
    return (bc != '0) && (int'(bc) <= MAX_BURST);
  endfunction

  // Illegal burstcounts collapse to a single beat.
  function automatic logic [BURST_W-1:0] burst_len(input logic [BURST_W-1:0] bc);
    return burst_ok(bc) ? bc : BURST_W'(1);
  endfunction

endpackage

// File: rtl/kband_m0_responder_if.sv
// Avalon-MM burst slave bus between the accelerator m0 master and the responder.
interface kband_m0_responder_if #(
  parameter int ADDR_W = 30
);
  import kband_resp_pkg::*;

  logic [ADDR_W-1:0]  s_address;
  logic [BURST_W-1:0] s_burstcount;
  logic [DATA_W-1:0]  s_writedata;
  logic [BE_W-1:0]    s_byteenable;
  logic               s_write;
  logic               s_read;
  logic               s_debugaccess;
  logic               s_waitrequest;
  logic [DATA_W-1:0]  s_readdata;
  logic               s_readdatavalid;

  modport master (
    output s_address, s_burstcount, s_writedata, s_byteenable,
           s_write, s_read, s_debugaccess,
    input  s_waitrequest, s_readdata, s_readdatavalid
  );

  modport slave (
    input  s_address, s_burstcount, s_writedata, s_byteenable,
           s_write, s_read, s_debugaccess,
    output s_waitrequest, s_readdata, s_readdatavalid
  );

endinterface

// File: rtl/kband_m0_responder_ram.sv
// Simple dual-port RAM, 2^DEPTH_LOG2 x 128, byte-lane write enables,
// registered read (1-cycle latency). Contents are never reset.
module kband_resp_ram
  import kband_resp_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [BE_W-1:0]       wbe,
  input  logic                  re,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [DATA_W-1:0]     rdata
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  // One independent byte-wide memory per lane keeps each lane's write
  // enable local to its own array.
  genvar gi;
  generate
    for (gi = 0; gi < BE_W; gi++) begin : g_lane
      logic [7:0] mem [0:DEPTH-1];
      logic [7:0] q_reg;

      // Lane write under its byte enable, plus registered read.
      always_ff @(posedge clk) begin
        if (we && wbe[gi]) begin
          mem[waddr] <= wdata[8*gi +: 8];
        end
        if (re) begin
          q_reg <= mem[raddr];
        end
      end

      assign rdata[8*gi +: 8] = q_reg;
    end
  endgenerate

endmodule

// File: rtl/kband_m0_responder.sv
// Avalon-MM burst slave terminating the KBand m0 port into on-chip RAM.
// Writes land at the accepting edge; reads stream back count beats with
// readdatavalid high in cycles 2..count+1 after the accepting edge.
module kband_m0_responder
  import kband_resp_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10,
  parameter int ADDR_W     = 30
) (
  input  logic                 clk_clk,
  input  logic                 reset_reset_n,
  kband_m0_responder_if.slave  s,
  output logic                 err_sticky
);

  state_t                state_reg, state_next;
  logic [DEPTH_LOG2-1:0] idx_reg, idx_next;
  logic [BURST_W-1:0]    cnt_reg, cnt_next;
  logic                  wait_reg, wait_next;
  logic                  rvalid_reg, rvalid_next;
  logic                  err_reg, err_next;

  logic [DEPTH_LOG2-1:0] cmd_idx;
  logic [BURST_W-1:0]    cmd_len;
  logic                  cmd_bad;
  logic                  ram_we;
  logic [DEPTH_LOG2-1:0] ram_waddr;
  logic                  ram_re;
  logic [DATA_W-1:0]     ram_rdata;

  // Address bits outside the RAM word index and debugaccess carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{s.s_debugaccess, s.s_address[ADDR_W-1:DEPTH_LOG2+4], s.s_address[3:0]};

  assign cmd_idx = s.s_address[DEPTH_LOG2+3:4];
  assign cmd_len = burst_len(s.s_burstcount);
  assign cmd_bad = !burst_ok(s.s_burstcount);

  // Next-state, beat bookkeeping and RAM control.
  always_comb begin
    state_next  = state_reg;
    idx_next    = idx_reg;
    cnt_next    = cnt_reg;
    err_next    = err_reg;
    ram_we      = 1'b0;
    ram_waddr   = idx_reg;
    ram_re      = 1'b0;
    rvalid_next = 1'b0;

    unique case (state_reg)
      IDLE: begin
        // wait_reg is only high here in the first cycle after reset.
        if (!wait_reg) begin
          if (s.s_write) begin
            ram_we    = 1'b1;
            ram_waddr = cmd_idx;
            idx_next  = cmd_idx + 1'b1;
            cnt_next  = cmd_len - 1'b1;
            if (cmd_bad || s.s_read) begin
              err_next = 1'b1;
            end
            if (cmd_len != BURST_W'(1)) begin
              state_next = WBURST;
            end
          end else if (s.s_read) begin
            idx_next   = cmd_idx;
            cnt_next   = cmd_len;
            state_next = RBURST;
            if (cmd_bad) begin
              err_next = 1'b1;
            end
          end
        end
      end

      WBURST: begin
        if (s.s_read) begin
          err_next = 1'b1;
        end
        if (s.s_write) begin
          ram_we   = 1'b1;
          idx_next = idx_reg + 1'b1;
          cnt_next = cnt_reg - 1'b1;
          if (cnt_reg == BURST_W'(1)) begin
            state_next = IDLE;
          end
        end
      end

      RBURST: begin
        // One RAM read per cycle; the cycle after the last issue is the
        // last valid beat, and the slave reopens on the following edge.
        if (cnt_reg != '0) begin
          ram_re      = 1'b1;
          rvalid_next = 1'b1;
          idx_next    = idx_reg + 1'b1;
          cnt_next    = cnt_reg - 1'b1;
        end else begin
          state_next = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase

    wait_next = (state_next == RBURST);
  end

  // State and output registers; reset stalls the bus until the first edge.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_reg  <= IDLE;
      idx_reg    <= '0;
      cnt_reg    <= '0;
      wait_reg   <= 1'b1;
      rvalid_reg <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      idx_reg    <= idx_next;
      cnt_reg    <= cnt_next;
      wait_reg   <= wait_next;
      rvalid_reg <= rvalid_next;
      err_reg    <= err_next;
    end
  end

  kband_resp_ram #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_ram (
    .clk   (clk_clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (s.s_writedata),
    .wbe   (s.s_byteenable),
    .re    (ram_re),
    .raddr (idx_reg),
    .rdata (ram_rdata)
  );

  // RAM output register has no reset, so readdata is zeroed outside valid beats.
  assign s.s_readdata      = rvalid_reg ? ram_rdata : '0;
  assign s.s_readdatavalid = rvalid_reg;
  assign s.s_waitrequest   = wait_reg;
  assign err_sticky        = err_reg;

endmodule

// File: tb/tb_kband_m0_responder.sv
// Directed bench for kband_m0_responder: read data is checked by a
// scoreboard monitor, handshake timing and error flag by the stimulus.
module tb_kband_m0_responder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic err_sticky;

  int checks = 0;
  int failures = 0;

  logic [127:0] exp_q [$];
  logic [127:0] mon_exp;
  logic [127:0] wdat [16];
  logic [127:0] rexp [16];

  kband_m0_responder_if #(.ADDR_W(30)) bus ();

  kband_m0_responder #(
    .DEPTH_LOG2(10),
    .ADDR_W(30)
  ) dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .s             (bus),
    .err_sticky    (err_sticky)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic chk_i(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask

  // Scoreboard monitor: every valid beat must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && bus.s_readdatavalid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rd_unexpected got=%h exp=none", bus.s_readdata);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("rd_data", bus.s_readdata, mon_exp);
      end
    end
  end

  // Hold the current command until the slave stops stalling (bounded).
  task automatic wait_idle();
    int n = 0;
    while (bus.s_waitrequest && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (bus.s_waitrequest) begin
      checks++;
      failures++;
      $display("FAIL wait_timeout got=1 exp=0");
    end
  endtask

  task automatic wr_burst(input logic [29:0] addr, input logic [4:0] bc,
                          input logic [15:0] be, input int nbeats, input int gap_at);
    bus.s_address    = addr;
    bus.s_burstcount = bc;
    bus.s_byteenable = be;
    for (int i = 0; i < nbeats; i++) begin
      bus.s_writedata = wdat[i];
      bus.s_write     = 1'b1;
      wait_idle();
      @(posedge clk);
      #1;
      bus.s_write = 1'b0;
      if (i == gap_at) begin
        repeat (3) begin
          @(posedge clk);
          #1;
        end
      end
    end
    $display("WR addr=%h bc=%0d be=%h beats=%0d", addr, bc, be, nbeats);
  endtask

  // Read; nexp is the number of beats the slave should actually return.
  task automatic rd(input logic [29:0] addr, input logic [4:0] bc, input int nexp);
    int nb = 0;
    int first = -1;
    int last = -1;
    int werr = 0;
    for (int i = 0; i < nexp; i++) exp_q.push_back(rexp[i]);
    bus.s_address    = addr;
    bus.s_burstcount = bc;
    bus.s_read       = 1'b1;
    wait_idle();
    @(posedge clk);
    #1;
    bus.s_read = 1'b0;
    for (int c = 1; c <= nexp + 4; c++) begin
      @(negedge clk);
      if (bus.s_readdatavalid) begin
        nb++;
        if (first < 0) first = c;
        last = c;
      end
      if (bus.s_waitrequest !== (c <= nexp + 1)) werr++;
    end
    chk_i("rd_beats", nb, nexp);
    chk_i("rd_first_cycle", first, 2);
    chk_i("rd_contiguous", last - first + 1, nexp);
    chk_i("rd_wait_timing", werr, 0);
    chk_i("rd_q_drained", exp_q.size(), 0);
    $display("RD addr=%h bc=%0d beats=%0d", addr, bc, nb);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_wait_before_edge", 128'(bus.s_waitrequest), 128'(1));
    @(posedge clk);
    #1;
    chk("rst_wait_after_edge", 128'(bus.s_waitrequest), 128'(0));
  endtask

  initial begin
    int nv;
    bus.s_address     = '0;
    bus.s_burstcount  = 5'd1;
    bus.s_writedata   = '0;
    bus.s_byteenable  = '0;
    bus.s_write       = 1'b0;
    bus.s_read        = 1'b0;
    bus.s_debugaccess = 1'b0;

    // Reset state.
    repeat (2) @(negedge clk);
    chk("reset_wait", 128'(bus.s_waitrequest), 128'(1));
    chk("reset_rvalid", 128'(bus.s_readdatavalid), 128'(0));
    chk("reset_rdata", bus.s_readdata, 128'(0));
    chk("reset_err", 128'(err_sticky), 128'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("release_wait_before_edge", 128'(bus.s_waitrequest), 128'(1));
    @(posedge clk);
    #1;
    chk("release_wait_after_edge", 128'(bus.s_waitrequest), 128'(0));

    // Single-beat write then read at word 16.
    wdat[0] = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
    wr_burst(30'h100, 5'd1, 16'hFFFF, 1, -1);
    rexp[0] = wdat[0];
    rd(30'h100, 5'd1, 1);
    chk("t1_err", 128'(err_sticky), 128'(0));

    // Full 16-beat burst at word 1020 with a 3-cycle gap, wrapping to word 0.
    for (int i = 0; i < 16; i++) wdat[i] = 128'(i);
    wr_burst(30'h3FC0, 5'd16, 16'hFFFF, 16, 5);
    for (int i = 0; i < 16; i++) rexp[i] = 128'(i);
    rd(30'h3FC0, 5'd16, 16);
    for (int i = 0; i < 4; i++) rexp[i] = 128'(i + 4);
    rd(30'h0, 5'd4, 4);
    rexp[0] = 128'd3;
    rexp[1] = 128'd4;
    rd(30'h3FF0, 5'd2, 2);

    // Byteenable masking at word 5.
    wdat[0] = {128{1'b1}};
    wr_burst(30'h50, 5'd1, 16'hFFFF, 1, -1);
    wdat[0] = '0;
    wr_burst(30'h50, 5'd1, 16'h00F0, 1, -1);
    rexp[0] = {64'hFFFFFFFF_FFFFFFFF, 32'h0, 32'hFFFFFFFF};
    rd(30'h50, 5'd1, 1);
    chk("be_err", 128'(err_sticky), 128'(0));

    // Reset in the middle of an 8-beat read from word 1020.
    for (int i = 0; i < 8; i++) begin
      rexp[i] = 128'(i);
      exp_q.push_back(rexp[i]);
    end
    bus.s_address    = 30'h3FC0;
    bus.s_burstcount = 5'd8;
    bus.s_read       = 1'b1;
    wait_idle();
    @(posedge clk);
    #1;
    bus.s_read = 1'b0;
    nv = 0;
    for (int c = 0; c < 20 && nv < 3; c++) begin
      @(negedge clk);
      if (bus.s_readdatavalid) nv++;
    end
    chk_i("midrst_beats_before", nv, 3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_rvalid_async", 128'(bus.s_readdatavalid), 128'(0));
    chk("midrst_wait", 128'(bus.s_waitrequest), 128'(1));
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_wait_before_edge", 128'(bus.s_waitrequest), 128'(1));
    @(posedge clk);
    #1;
    chk("midrst_wait_after_edge", 128'(bus.s_waitrequest), 128'(0));
    $display("RST mid-read after 3 beats");
    for (int i = 0; i < 4; i++) rexp[i] = 128'(i);
    rd(30'h3FC0, 5'd4, 4);

    // read+write together: performed as a write, error flagged.
    bus.s_address    = 30'h280;
    bus.s_burstcount = 5'd1;
    bus.s_byteenable = 16'hFFFF;
    bus.s_writedata  = 128'h5A5A_0000_1111_2222_3333_4444_5555_A5A5;
    bus.s_write      = 1'b1;
    bus.s_read       = 1'b1;
    wait_idle();
    @(posedge clk);
    #1;
    bus.s_write = 1'b0;
    bus.s_read  = 1'b0;
    $display("WR+RD addr=%h collision", 30'h280);
    @(negedge clk);
    chk("collide_err", 128'(err_sticky), 128'(1));
    rexp[0] = 128'h5A5A_0000_1111_2222_3333_4444_5555_A5A5;
    rd(30'h280, 5'd1, 1);

    // Reset clears the flag; burstcount 0 returns exactly one beat and flags.
    do_reset();
    chk("post_reset_err", 128'(err_sticky), 128'(0));
    rd(30'h280, 5'd0, 1);
    chk("bc0_err", 128'(err_sticky), 128'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

endmodule
